fifo_uart_tx: RTL

Transmit-side consumer for the peripheral FIFO: pops bytes from the read port of a FIFO instance and serialises each one as an asynchronous UART frame on `tx`. It sits between the TX FIFO, which is filled by the bus-side register writer, and the chip pad. It is the reader for that writer. Frames go back-to-back with no idle gap while data is available.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_counter.sv | 26 ++
 rtl/fifo_uart_tx.sv | 117 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the FIFO-fed transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Total CLK cycles of one frame: start + data + optional parity + stop bits.
    function automatic int frame_len(input int num_bits, input int par_en,
                                     input int stop_bits, input int clks_per_bit);
        return (1 + num_bits + par_en + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Loadable down-counter; tick marks the last CLK cycle of a bit period.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic load,
    output logic tick
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt;

    // Reload at bit boundaries, otherwise count down and park at zero.
    always_ff @(posedge CLK) begin
        if (RST)
            cnt <= '0;
        else if (load)
            cnt <= CW'(CLKS_PER_BIT - 1);
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO reader that serialises popped bytes as back-to-back UART frames.
import uart_pkg::*;

module fifo_uart_tx #(
    parameter int NUM_BITS     = 8,
    parameter int addr_bits    = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 enable,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 empty,
    input  logic [addr_bits-1:0] numdata,
    input  logic [NUM_BITS-1:0]  rdata,
    output logic                 REN,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int MAXB = (NUM_BITS > STOP_BITS) ? NUM_BITS : STOP_BITS;
    localparam int BW   = $clog2(MAXB) + 1;

    state_t              state;
    logic [NUM_BITS-1:0] shift;
    logic [NUM_BITS-1:0] shift_nxt;
    logic [BW-1:0]       bit_cnt;
    logic                par_en_q;
    logic                par_bit_q;
    logic                tick;
    logic                bit_end;
    logic                last_stop;

    // Occupancy is informational only; control uses the empty flag.
    logic unused_numdata;
    assign unused_numdata = ^numdata;

    assign shift_nxt = shift >> 1;
    assign bit_end   = (state != IDLE) && tick;
    assign last_stop = (state == STOP) && tick && (bit_cnt == BW'(STOP_BITS - 1));

    // Pop when idle or finishing a frame, so frames chain without a gap.
    assign REN        = !RST && enable && !empty && ((state == IDLE) || last_stop);
    assign busy       = (state != IDLE);
    assign frame_done = last_stop;

    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .CLK  (CLK),
        .RST  (RST),
        .load (REN || bit_end),
        .tick (tick)
    );

    // Frame FSM; tx is registered with the value of the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            tx        <= 1'b1;
            shift     <= '0;
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (REN) begin
            shift     <= rdata;
            par_en_q  <= parity_en;
            par_bit_q <= ^rdata ^ parity_odd;
            bit_cnt   <= '0;
            state     <= START;
            tx        <= 1'b0;
        end else if (bit_end) begin
            case (state)
                START: begin
                    state   <= DATA;
                    tx      <= shift[0];
                    bit_cnt <= '0;
                end
                DATA: begin
                    if (bit_cnt == BW'(NUM_BITS - 1)) begin
                        bit_cnt <= '0;
                        if (par_en_q) begin
                            state <= PARITY;
                            tx    <= par_bit_q;
                        end else begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shift   <= shift_nxt;
                        tx      <= shift_nxt[0];
                    end
                end
                PARITY: begin
                    state   <= STOP;
                    tx      <= 1'b1;
                    bit_cnt <= '0;
                end
                STOP: begin
                    tx <= 1'b1;
                    if (last_stop) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
